// File: rtl/lingret_alu_pipe.sv
// rtl/lingret_alu_pipe.sv - handshaked Lingret ALU with registered result, flags and accumulator
//
// Purpose:
//   Accepts one instruction/operand pair per i_valid/o_ready transfer and
//   presents a registered result with {Z,N,C,V} flags under o_valid/i_ready.
//   Every result also loads an internal accumulator; instruction bit 3 (ACC)
//   substitutes the accumulator for operand A.
//
// Configuration:
//   LINGRET_ALU_MUL_EN - when defined, opcode 110 runs a WIDTH-cycle shift-add
//   multiplier (o_ready low while it runs). When undefined, opcode 110 gives
//   result 0 with latency 1, same as opcode 111.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous reset, active-high
//   i_valid        upstream request valid
//   o_ready        request can be accepted this cycle
//   i_instruction  [2:0] opcode, [3] ACC, [7:4] ignored
//   i_data_0       operand A (unless ACC)
//   i_data_1       operand B
//   o_valid        o_result/o_flags valid
//   i_ready        downstream accepts result
//   o_result       registered result
//   o_flags        {Z,N,C,V} of o_result

module lingret_alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_instruction,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  // Output / accumulator registers
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Instruction decode
  logic [2:0]       opcode;
  logic             use_acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             unused_instr_bits;

  assign opcode            = i_instruction[2:0];
  assign use_acc           = i_instruction[3];
  assign op_a              = use_acc ? acc_q : i_data_0;
  assign op_b              = i_data_1;
  assign unused_instr_bits = ^i_instruction[7:4];

  logic accept;
  logic is_idle;
  logic start_single;

  // A new request may enter only when no multiply is running and the output
  // register is empty or draining on this same edge.
  assign o_ready = is_idle & (~valid_q | i_ready);
  assign accept  = i_valid & o_ready;

  // Single-cycle ALU
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    add_full = {1'b0, op_a} + {1'b0, op_b};
    sub_full = {1'b0, op_b} - {1'b0, op_a};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (opcode)
      OP_OR:   alu_res = op_a | op_b;
      OP_NAND: alu_res = ~(op_a & op_b);
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_AND:  alu_res = op_a & op_b;
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        // B - A; carry means "no borrow", i.e. B >= A unsigned
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];
        alu_v   = (op_b[WIDTH-1] != op_a[WIDTH-1]) && (alu_res[WIDTH-1] != op_b[WIDTH-1]);
      end
      // Multiply, when enabled, never loads from this path.
      OP_MUL:  alu_res = '0;
      OP_ZERO: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef LINGRET_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_next;
  logic               mul_done;

  assign is_idle      = (state_q == S_IDLE);
  assign start_single = accept & (opcode != OP_MUL);

  // Shift-add: each cycle add the multiplicand if the current multiplier LSB
  // is set, then shift multiplicand left and multiplier right.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    mul_done  = 1'b0;
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (accept && (opcode == OP_MUL)) begin
          state_d  = S_MUL;
          mcand_d  = {{WIDTH{1'b0}}, op_a};
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      S_MUL: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          mul_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign is_idle      = 1'b1;
  assign start_single = accept;
`endif

  // Result register: holds while stalled, clears valid on drain unless a new
  // result lands on the same edge.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    valid_d  = valid_q & ~i_ready;
    if (start_single) begin
      result_d = alu_res;
      flags_d  = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
      acc_d    = alu_res;
      valid_d  = 1'b1;
    end
`ifdef LINGRET_ALU_MUL_EN
    else if (mul_done) begin
      result_d = prod_next[WIDTH-1:0];
      flags_d  = {prod_next[WIDTH-1:0] == '0, prod_next[WIDTH-1],
                  |prod_next[2*WIDTH-1:WIDTH], 1'b0};
      acc_d    = prod_next[WIDTH-1:0];
      valid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule
